// File: rtl/wed_writeback_control_pkg.sv
// ---------------------------------------------------------------------------
// wed_writeback_control_pkg
// Shared types and constants for the WED writeback path: the writeback FSM
// state encoding, CAPI opcode/response constants, the WED request layout and
// the WED -> host cacheline serialisation helpers.
// ---------------------------------------------------------------------------
package wed_writeback_control_pkg;

    typedef enum logic [2:0] {
        WB_RESET,
        WB_IDLE,
        WB_REQ,
        WB_WAITING_FOR_RESPONSE,
        WB_DONE,
        WB_ERROR
    } wb_state_t;

    localparam logic [12:0] CMD_WRITE_NA  = 13'h0D00;
    localparam logic [11:0] WB_LINE_BYTES = 12'd128;
    localparam logic [7:0]  RESP_DONE     = 8'h00;
    localparam logic [7:0]  RESP_PAGED    = 8'h0A;

    // Sixteen 64-bit WED fields, field 0 (size_send) first.
    typedef logic [0:15][0:63] wed_fields_t;
    typedef logic [0:1023]     wb_line_t;

    typedef struct packed {
        logic        valid;
        logic [0:63] address;
        wed_fields_t wed;
    } wed_request_t;

    // Reverse the byte order of one double word (host is little-endian).
    function automatic logic [0:63] swap_endianness_double_word(input logic [0:63] d);
        logic [0:63] r;
        for (int b = 0; b < 8; b++) begin
            r[8*b +: 8] = d[56-8*b +: 8];
        end
        return r;
    endfunction

    // Field k lands byte-swapped in line bits [64k : 64k+63]; the exact
    // inverse of the fetch-side mapping.
    function automatic wb_line_t map_WED_to_DataArrays(input wed_fields_t wed);
        wb_line_t line;
        for (int k = 0; k < 16; k++) begin
            line[64*k +: 64] = swap_endianness_double_word(wed[k]);
        end
        return line;
    endfunction

endpackage

// File: rtl/wed_writeback_control.sv
// ---------------------------------------------------------------------------
// wed_writeback_control
// Writes the current WED back to host memory as one 128-byte WRITE_NA,
// serves the PSL buffer reads for that line, retries PAGED responses and
// reports done/error to the AFU control.
//
// Ports:
//   clock, rstn              clock, asynchronous active-low reset
//   enabled_in               job running; low aborts to idle
//   wed_request_in           valid, address, 16 WED fields
//   writeback_start_in       one-cycle writeback request
//   command_credit_in        PSL command credit available
//   command_out_*            CAPI command (valid, opcode, address, size, tag)
//   ha_brvalid/brtag/brad    PSL buffer read request
//   brdata_out_valid/brdata_out  buffer read data, BRLAT cycles after request
//   ha_rvalid/rtag/response  PSL response
//   busy_out, done_out, error_out  status to AFU control
// ---------------------------------------------------------------------------
module wed_writeback_control
    import wed_writeback_control_pkg::*;
#(
    parameter logic [7:0] WB_TAG    = 8'h3F,
    parameter int         MAX_RETRY = 4,
    parameter int         BRLAT     = 1
) (
    input  logic          clock,
    input  logic          rstn,
    input  logic          enabled_in,
    input  wed_request_t  wed_request_in,
    input  logic          writeback_start_in,
    input  logic          command_credit_in,
    output logic          command_out_valid,
    output logic [12:0]   command_out_command,
    output logic [63:0]   command_out_address,
    output logic [11:0]   command_out_size,
    output logic [7:0]    command_out_tag,
    input  logic          ha_brvalid,
    input  logic [7:0]    ha_brtag,
    input  logic [5:0]    ha_brad,
    output logic          brdata_out_valid,
    output logic [0:511]  brdata_out,
    input  logic          ha_rvalid,
    input  logic [7:0]    ha_rtag,
    input  logic [7:0]    ha_response,
    output logic          busy_out,
    output logic          done_out,
    output logic [7:0]    error_out
);

    localparam int             RW    = $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0]  MAX_R = RW'(MAX_RETRY);

    wb_state_t      state_q;
    logic [RW-1:0]  retry_q;
    logic [0:63]    addr_q;
    wb_line_t       line_q;
    logic           cmd_valid_q;
    logic [12:0]    cmd_command_q;
    logic [11:0]    cmd_size_q;
    logic [7:0]     cmd_tag_q;
    logic           busy_q;
    logic           done_q;
    logic [7:0]     error_q;

    logic           rsp_hit;
    assign rsp_hit = ha_rvalid && (ha_rtag == WB_TAG);

    // Writeback FSM; status outputs are registered alongside the state so
    // they line up with the state they describe.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q       <= WB_RESET;
            retry_q       <= '0;
            addr_q        <= '0;
            line_q        <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_command_q <= '0;
            cmd_size_q    <= '0;
            cmd_tag_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= '0;
        end else begin
            cmd_valid_q <= 1'b0;
            done_q      <= 1'b0;
            if (state_q != WB_RESET && !enabled_in) begin
                state_q <= WB_IDLE;
                busy_q  <= 1'b0;
                error_q <= '0;
            end else begin
                unique case (state_q)
                    WB_RESET: state_q <= WB_IDLE;
                    WB_IDLE: begin
                        if (writeback_start_in && wed_request_in.valid) begin
                            addr_q  <= wed_request_in.address;
                            line_q  <= map_WED_to_DataArrays(wed_request_in.wed);
                            retry_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= WB_REQ;
                        end
                    end
                    WB_REQ: begin
                        if (command_credit_in) begin
                            cmd_valid_q   <= 1'b1;
                            cmd_command_q <= CMD_WRITE_NA;
                            cmd_size_q    <= WB_LINE_BYTES;
                            cmd_tag_q     <= WB_TAG;
                            state_q       <= WB_WAITING_FOR_RESPONSE;
                        end
                    end
                    WB_WAITING_FOR_RESPONSE: begin
                        if (rsp_hit) begin
                            if (ha_response == RESP_DONE) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= WB_DONE;
                            end else if (ha_response == RESP_PAGED && retry_q < MAX_R) begin
                                retry_q <= retry_q + RW'(1);
                                state_q <= WB_REQ;
                            end else begin
                                busy_q  <= 1'b0;
                                error_q <= ha_response;
                                state_q <= WB_ERROR;
                            end
                        end
                    end
                    WB_DONE:  state_q <= WB_IDLE;
                    WB_ERROR: state_q <= WB_ERROR;
                    default:  state_q <= WB_IDLE;
                endcase
            end
        end
    end

    // Buffer read path: independent of the FSM so reads are served in any
    // state. Requests are delayed BRLAT-1 cycles, then the half-line is
    // registered onto brdata_out (total latency BRLAT).
    logic rd_req;
    logic rd_valid;
    logic rd_half;
    logic unused_brad;
    assign rd_req      = ha_brvalid && (ha_brtag == WB_TAG);
    assign unused_brad = ^ha_brad[4:0];

    generate
        if (BRLAT <= 1) begin : g_br_direct
            assign rd_valid = rd_req;
            assign rd_half  = ha_brad[5];
        end else begin : g_br_pipe
            logic [BRLAT-2:0] valid_pipe_q;
            logic [BRLAT-2:0] half_pipe_q;
            always_ff @(posedge clock or negedge rstn) begin
                if (!rstn) begin
                    valid_pipe_q <= '0;
                    half_pipe_q  <= '0;
                end else begin
                    valid_pipe_q[0] <= rd_req;
                    half_pipe_q[0]  <= ha_brad[5];
                    for (int i = 1; i < BRLAT - 1; i++) begin
                        valid_pipe_q[i] <= valid_pipe_q[i-1];
                        half_pipe_q[i]  <= half_pipe_q[i-1];
                    end
                end
            end
            assign rd_valid = valid_pipe_q[BRLAT-2];
            assign rd_half  = half_pipe_q[BRLAT-2];
        end
    endgenerate

    logic         br_valid_q;
    logic [0:511] br_data_q;

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            br_valid_q <= 1'b0;
            br_data_q  <= '0;
        end else begin
            br_valid_q <= rd_valid;
            if (rd_valid) begin
                br_data_q <= rd_half ? line_q[512:1023] : line_q[0:511];
            end
        end
    end

    assign command_out_valid   = cmd_valid_q;
    assign command_out_command = cmd_command_q;
    assign command_out_address = addr_q;
    assign command_out_size    = cmd_size_q;
    assign command_out_tag     = cmd_tag_q;
    assign brdata_out_valid    = br_valid_q;
    assign brdata_out          = br_data_q;
    assign busy_out            = busy_q;
    assign done_out            = done_q;
    assign error_out           = error_q;

endmodule

// File: tb/tb_wed_writeback_control.sv
`timescale 1ns/1ps
module tb_wed_writeback_control;
    import wed_writeback_control_pkg::*;

    localparam logic [7:0] TAG  = 8'h3F;
    localparam int         MAXR = 4;
    localparam int         LAT  = 1;

    logic          clock = 1'b0;
    logic          rstn = 1'b0;
    logic          enabled_in = 1'b0;
    wed_request_t  wed_request_in = '0;
    logic          writeback_start_in = 1'b0;
    logic          command_credit_in = 1'b0;
    logic          command_out_valid;
    logic [12:0]   command_out_command;
    logic [63:0]   command_out_address;
    logic [11:0]   command_out_size;
    logic [7:0]    command_out_tag;
    logic          ha_brvalid = 1'b0;
    logic [7:0]    ha_brtag = '0;
    logic [5:0]    ha_brad = '0;
    logic          brdata_out_valid;
    logic [0:511]  brdata_out;
    logic          ha_rvalid = 1'b0;
    logic [7:0]    ha_rtag = '0;
    logic [7:0]    ha_response = '0;
    logic          busy_out;
    logic          done_out;
    logic [7:0]    error_out;

    wed_writeback_control #(.WB_TAG(TAG), .MAX_RETRY(MAXR), .BRLAT(LAT)) dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in),
        .wed_request_in(wed_request_in), .writeback_start_in(writeback_start_in),
        .command_credit_in(command_credit_in),
        .command_out_valid(command_out_valid), .command_out_command(command_out_command),
        .command_out_address(command_out_address), .command_out_size(command_out_size),
        .command_out_tag(command_out_tag),
        .ha_brvalid(ha_brvalid), .ha_brtag(ha_brtag), .ha_brad(ha_brad),
        .brdata_out_valid(brdata_out_valid), .brdata_out(brdata_out),
        .ha_rvalid(ha_rvalid), .ha_rtag(ha_rtag), .ha_response(ha_response),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { logic [63:0] addr; int cyc; } cmd_exp_t;
    typedef struct { logic [0:511] data; int cyc; } br_exp_t;
    cmd_exp_t cmd_q[$];
    br_exp_t  br_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int cmd_seen = 0;
    int done_seen = 0;

    logic [63:0]  fields [16];
    logic [0:511] last_exp = '0;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] bswap(input logic [63:0] x);
        return {<<8{x}};
    endfunction

    // Expected half-line: field 0 (or 8) ends up in the most significant slot.
    function automatic logic [0:511] exp_half(input bit h);
        logic [0:511] r;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[64:511], bswap(fields[h ? 8 + k : k])};
        return r;
    endfunction

    // Scoreboard monitor: one line per observed transaction.
    always @(negedge clock) begin
        if (rstn) begin
            if (command_out_valid) begin
                cmd_seen++;
                $display("[TB] cyc %0d cmd %h addr %h size %0d tag %h", cyc,
                         command_out_command, command_out_address, command_out_size, command_out_tag);
                if (cmd_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL cmd_unexpected: got command at cyc %0d expected none", cyc);
                end else begin
                    cmd_exp_t e;
                    e = cmd_q.pop_front();
                    check("cmd_addr", command_out_address, e.addr);
                    check("cmd_opcode", command_out_command, 13'h0D00);
                    check("cmd_size", command_out_size, 12'd128);
                    check("cmd_tag", command_out_tag, TAG);
                    check("cmd_cycle", cyc, e.cyc);
                end
            end
            if (brdata_out_valid) begin
                $display("[TB] cyc %0d brdata %h...", cyc, brdata_out[0:63]);
                if (br_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL br_unexpected: got brdata at cyc %0d expected none", cyc);
                end else begin
                    br_exp_t b;
                    b = br_q.pop_front();
                    check("br_data", brdata_out, b.data);
                    check("br_cycle", cyc, b.cyc);
                end
            end
            if (done_out) done_seen++;
        end
    end

    task automatic set_fields(input logic [63:0] seed);
        for (int k = 0; k < 16; k++) fields[k] = seed ^ (64'h1111_0000_0000_0000 * k) ^ k;
    endtask

    task automatic do_start(input logic [63:0] addr, input bit expect_cmd);
        wed_request_in.valid   = 1'b1;
        wed_request_in.address = addr;
        for (int k = 0; k < 16; k++) wed_request_in.wed[k] = fields[k];
        writeback_start_in = 1'b1;
        if (expect_cmd) cmd_q.push_back('{addr, cyc + 2});
        @(negedge clock);
        writeback_start_in = 1'b0;
    endtask

    task automatic respond(input logic [7:0] code, input logic [7:0] tag);
        ha_rvalid = 1'b1; ha_rtag = tag; ha_response = code;
        @(negedge clock);
        ha_rvalid = 1'b0;
    endtask

    task automatic br_read(input logic [7:0] tag, input logic [5:0] brad);
        ha_brvalid = 1'b1; ha_brtag = tag; ha_brad = brad;
        if (tag == TAG) begin
            last_exp = exp_half(brad[5]);
            br_q.push_back('{last_exp, cyc + LAT});
        end
    endtask

    typedef struct {
        int n_paged; bit has_final; logic [7:0] final_code;
        bit exp_done; logic [7:0] exp_err; int exp_cmds;
    } resp_vec_t;

    typedef struct { logic [7:0] tag; logic [5:0] brad; bit exp_valid; } br_vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        resp_vec_t rv[6];
        br_vec_t   bv[8];
        int c0, d0, retries;

        rv[0] = '{0, 1'b1, 8'h00, 1'b1, 8'h00, 1};
        rv[1] = '{4, 1'b1, 8'h00, 1'b1, 8'h00, 5};
        rv[2] = '{5, 1'b0, 8'h00, 1'b0, 8'h0A, 5};
        rv[3] = '{0, 1'b1, 8'h01, 1'b0, 8'h01, 1};
        rv[4] = '{2, 1'b1, 8'h00, 1'b1, 8'h00, 3};
        rv[5] = '{1, 1'b1, 8'h05, 1'b0, 8'h05, 2};

        bv[0] = '{TAG,   6'd0,  1'b1};
        bv[1] = '{TAG,   6'd32, 1'b1};
        bv[2] = '{8'h10, 6'd0,  1'b0};
        bv[3] = '{TAG,   6'd33, 1'b1};
        bv[4] = '{TAG,   6'd31, 1'b1};
        bv[5] = '{8'h3E, 6'd32, 1'b0};
        bv[6] = '{8'h00, 6'd0,  1'b0};
        bv[7] = '{TAG,   6'd63, 1'b1};

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_cmd_valid", command_out_valid, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_error", error_out, 8'h00);
        check("rst_br_valid", brdata_out_valid, 1'b0);
        check("rst_brdata", brdata_out, 512'h0);
        rstn = 1'b1; enabled_in = 1'b1; command_credit_in = 1'b1;
        repeat (2) @(negedge clock);

        // Basic writeback
        set_fields(64'hA5A5_0000_1234_5678);
        fields[0] = 64'h0102030405060708;
        d0 = done_seen;
        do_start(64'h1000, 1'b1);
        check("busy_in_req", busy_out, 1'b1);
        repeat (2) @(negedge clock);
        br_read(TAG, 6'd0);
        @(negedge clock);
        ha_brvalid = 1'b0;
        check("br_first_dw", brdata_out[0:63], 64'h0807060504030201);
        respond(RESP_DONE, TAG);
        check("basic_done", done_out, 1'b1);
        check("basic_busy", busy_out, 1'b0);
        @(negedge clock);
        check("done_one_cycle", done_out, 1'b0);
        check("basic_done_count", done_seen - d0, 1);

        // Start with valid low is ignored
        c0 = cmd_seen;
        wed_request_in.valid = 1'b0;
        writeback_start_in = 1'b1;
        @(negedge clock);
        writeback_start_in = 1'b0;
        repeat (3) @(negedge clock);
        check("novalid_busy", busy_out, 1'b0);
        check("novalid_cmds", cmd_seen - c0, 0);

        // Response outcome table
        for (int i = 0; i < 6; i++) begin
            c0 = cmd_seen; d0 = done_seen; retries = 0;
            set_fields(64'h0F0F_0000_0000_0000 + 64'(i));
            do_start(64'h2000 + 64'(i * 128), 1'b1);
            repeat (2) @(negedge clock);
            for (int p = 0; p < rv[i].n_paged; p++) begin
                if (retries < MAXR) cmd_q.push_back('{64'h2000 + 64'(i * 128), cyc + 2});
                retries++;
                respond(RESP_PAGED, TAG);
                repeat (2) @(negedge clock);
            end
            if (rv[i].has_final) begin
                respond(rv[i].final_code, TAG);
                check("vec_done_pulse", done_out, rv[i].exp_done);
            end
            repeat (3) @(negedge clock);
            check("vec_error", error_out, rv[i].exp_err);
            check("vec_done_count", done_seen - d0, rv[i].exp_done);
            check("vec_cmd_count", cmd_seen - c0, rv[i].exp_cmds);
            check("vec_busy", busy_out, 1'b0);
            check("vec_cmd_q_drained", cmd_q.size(), 0);
            enabled_in = 1'b0;
            @(negedge clock);
            check("vec_err_cleared", error_out, 8'h00);
            enabled_in = 1'b1;
            @(negedge clock);
        end

        // Credit held low
        c0 = cmd_seen;
        command_credit_in = 1'b0;
        set_fields(64'h5555_AAAA_0000_0001);
        do_start(64'h3000, 1'b0);
        repeat (10) @(negedge clock);
        check("nocredit_cmds", cmd_seen - c0, 0);
        check("nocredit_busy", busy_out, 1'b1);
        command_credit_in = 1'b1;
        cmd_q.push_back('{64'h3000, cyc + 1});
        repeat (3) @(negedge clock);
        check("credit_cmds", cmd_seen - c0, 1);

        // Foreign-tag response ignored while waiting
        d0 = done_seen;
        respond(RESP_DONE, 8'h10);
        check("foreign_busy", busy_out, 1'b1);
        check("foreign_done", done_out, 1'b0);

        // DONE together with a buffer read
        br_read(TAG, 6'd32);
        ha_rvalid = 1'b1; ha_rtag = TAG; ha_response = RESP_DONE;
        @(negedge clock);
        ha_rvalid = 1'b0; ha_brvalid = 1'b0;
        check("simul_done", done_out, 1'b1);
        check("simul_br_valid", brdata_out_valid, 1'b1);
        @(negedge clock);

        // Buffer read table, back-to-back
        for (int i = 0; i < 8; i++) begin
            br_read(bv[i].tag, bv[i].brad);
            @(negedge clock);
            check("br_tab_valid", brdata_out_valid, bv[i].exp_valid);
            if (!bv[i].exp_valid) check("br_tab_hold", brdata_out, last_exp);
        end
        ha_brvalid = 1'b0;
        @(negedge clock);

        // Asynchronous reset while waiting for a response
        d0 = done_seen;
        set_fields(64'h7777_0000_8888_0000);
        do_start(64'h4000, 1'b1);
        repeat (2) @(negedge clock);
        check("pre_rst_busy", busy_out, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("async_busy", busy_out, 1'b0);
        check("async_cmd_valid", command_out_valid, 1'b0);
        check("async_error", error_out, 8'h00);
        check("async_brdata", brdata_out, 512'h0);
        @(negedge clock);
        rstn = 1'b1;
        repeat (2) @(negedge clock);
        respond(RESP_DONE, TAG);
        check("late_done_ignored", done_out, 1'b0);
        check("late_busy", busy_out, 1'b0);
        for (int k = 0; k < 16; k++) fields[k] = '0;
        br_read(TAG, 6'd0);
        @(negedge clock);
        ha_brvalid = 1'b0;
        repeat (2) @(negedge clock);
        check("late_done_count", done_seen - d0, 0);

        check("final_cmd_q_empty", cmd_q.size(), 0);
        check("final_br_q_empty", br_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wed_writeback_control.md
Name: wed_writeback_control

Overview:
- Write-side counterpart of the WED fetch path: serialises the accelerator's current WED_request back into a 128-byte host cacheline and writes it to the WED address via a single CAPI WRITE_NA command.
- Serves buffer-read (ha_br*) requests for that line, waits for the PSL response, retries PAGED responses and reports done or error to the AFU control.
- Sits beside the WED fetch block inside the AFU control, sharing the job-enable and WED interface.

Parameters:
WB_TAG, 8'h3F, CAPI tag used for the writeback command; unique among AFU tags
MAX_RETRY, 4, PAGED responses tolerated before declaring error
BRLAT, 1, cycles from ha_brvalid to brdata_out_valid (1 or 3 only)

Ports:
clock  in  1  AFU clock
rstn  in  1  asynchronous active-low reset
enabled_in  in  1  job running; low aborts and holds the block in idle
wed_request_in  in  1089  WEDInterface: valid, address[0:63], wed (16x64)
writeback_start_in  in  1  one-cycle pulse requesting writeback
command_credit_in  in  1  at least one PSL command credit available
command_out_valid  out  1  command strobe, one cycle per issue
command_out_command  out  13  13'h0D00 (WRITE_NA)
command_out_address  out  64  snapshot WED address
command_out_size  out  12  12'd128
command_out_tag  out  8  WB_TAG
ha_brvalid  in  1  buffer read request
ha_brtag  in  8  buffer read tag
ha_brad  in  6  buffer read half-line address; bit 5 selects half
brdata_out_valid  out  1  buffer read data valid
brdata_out  out  512  half-line data
ha_rvalid  in  1  response valid
ha_rtag  in  8  response tag
ha_response  in  8  response code
busy_out  out  1  writeback in flight
done_out  out  1  one-cycle pulse on successful completion
error_out  out  8  sticky failing response code; 0 = none

Behaviour:
- Reset (rstn low, asynchronous): state WB_RESET; all outputs 0; retry counter 0; line buffer cleared. WB_RESET -> WB_IDLE on the first clock after release.
- States: WB_RESET, WB_IDLE, WB_REQ, WB_WAITING_FOR_RESPONSE, WB_DONE, WB_ERROR.
- WB_IDLE:
  - writeback_start_in & enabled_in & wed_request_in.valid: snapshot address, serialise wed into the 1024-bit line buffer, retry=0, go to WB_REQ.
  - A start with valid low is ignored.
- Serialisation, exact inverse of the fetch mapping: field k (k=0 for size_send through k=15 for pointer12) is byte-swapped as a double word into line bits [64k : 64k+63].
- WB_REQ:
  - When command_credit_in=1, assert command_out_valid with command, address, size and tag for exactly one cycle, then go to WB_WAITING_FOR_RESPONSE.
  - Without credit, wait with valid low.
- Buffer read, in any state:
  - On ha_brvalid with ha_brtag==WB_TAG, drive brdata_out BRLAT cycles later: ha_brad[5]=0 gives line[0:511], 1 gives line[512:1023]. brdata_out_valid is high for one cycle.
  - Back-to-back requests are pipelined, one per cycle.
  - Other tags produce nothing; brdata_out holds its last value.
- WB_WAITING_FOR_RESPONSE (only responses with ha_rtag==WB_TAG count):
  - 8'h00 DONE: go to WB_DONE.
  - 8'h0A PAGED: if retry<MAX_RETRY, increment retry and go to WB_REQ (reissue); otherwise error_out=8'h0A and go to WB_ERROR.
  - Any other code: error_out=code, go to WB_ERROR.
- WB_DONE: done_out=1 for one cycle, then WB_IDLE.
- WB_ERROR: hold; error_out sticky until enabled_in falls or reset.
- busy_out=1 in WB_REQ and WB_WAITING_FOR_RESPONSE.
- writeback_start_in outside WB_IDLE is ignored; there is no queueing.
- enabled_in low in any state except WB_RESET: next state WB_IDLE; command_out_valid, busy_out and error_out cleared. Late responses for WB_TAG while idle are ignored.
- Simultaneous ha_rvalid (DONE) and ha_brvalid in the same cycle: both honoured; brdata is still delivered after the state changes.
- All outputs are registered.

Decomposition:
- WED_PKG additions:
  - wb_state enum.
  - WRITE_NA opcode and RESP_DONE/RESP_PAGED constants, if not already in CAPI_PKG.
  - function map_WED_to_DataArrays (WED_request -> 1024-bit line, using swap_endianness_double_word).
- No sub-module; the BRLAT delay is a small in-module shift pipeline.

Test Plan:
- Start with address 64'h1000, size_send=64'h0102030405060708, enabled=1, credit=1 -> one command_out_valid with 0D00/1000/128/3F; later brad[5]=0 read returns brdata[0:63]=64'h0807060504030201 after 1 cycle; response 00 gives done_out pulse and busy_out=0.
- Credit held 0 for 10 cycles -> no command while credit is low; command issues the cycle credit rises; exactly one issue.
- PAGED x4 then DONE -> 5 commands total, then done_out. PAGED x5 -> error_out=8'h0A, WB_ERROR; enabled_in low clears it.
- Response 8'h01 (AERROR) -> error_out=01, no done_out. A response with tag 8'h10 while waiting is ignored; state unchanged.
- ha_brvalid on consecutive cycles with brad 0 then 32 (bit 5 set) -> both halves delivered on consecutive cycles. A brtag mismatch gives no brdata_out_valid.
- rstn low while in WB_WAITING_FOR_RESPONSE -> outputs 0 immediately, asynchronously; after release, the block idles and a late DONE is ignored.
